sync_fifo_reader: RTL and testbench

Read-side adapter for `sync_fifo`. It issues `rd_en` into the FIFO's read port, absorbs the FIFO's one-cycle registered read latency in a 2-entry skid buffer, and presents the data as a valid/ready stream. It sits between `sync_fifo` and any downstream consumer that applies backpressure. Sustained throughput is one beat per clock.

---
 rtl/sync_fifo_pkg.sv | 17 +
 rtl/sync_fifo_reader_skid.sv | 93 +++++++++
 rtl/sync_fifo_reader.sv | 102 ++++++++++
 tb/tb_sync_fifo_reader.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// ----------------------------------------------------------------------------
// sync_fifo_pkg
//   Definitions shared by the sync_fifo read-side adapter and its skid buffer.
//   - occ_e   : skid-buffer occupancy encoding (EMPTY / ONE / TWO)
//   - BEATS_W : width of the accepted-beat counter exposed as m_beats
// ----------------------------------------------------------------------------
package sync_fifo_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    localparam int BEATS_W = 16;

endpackage

// File: rtl/sync_fifo_reader_skid.sv
// ----------------------------------------------------------------------------
// sync_fifo_reader_skid
//   Two-entry in-order buffer that catches words returned by sync_fifo one
//   cycle after they were requested, and holds them until the consumer takes
//   them.
//
// Ports
//   clk_i    : clock, rising edge
//   sclr_i   : synchronous active-high reset; empties the buffer and zeroes
//              the storage
//   flush_i  : synchronous discard; empties the buffer, storage is left as is
//   push_i   : write din_i at the tail this cycle
//   pop_i    : head entry is consumed this cycle (only asserted when valid_o)
//   din_i    : data to write
//   occ_o    : current occupancy
//   valid_o  : buffer holds at least one entry
//   dout_o   : head entry
// ----------------------------------------------------------------------------
module sync_fifo_reader_skid
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  sclr_i,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    output occ_e                  occ_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] dout_o
);

    occ_e                  occ_q, occ_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [2];
    logic                  clr;

    // A flush in the same cycle as a push wins: the arriving word is dropped.
    assign clr = sclr_i | flush_i;

    always_comb begin
        occ_d    = occ_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr) begin
            occ_d    = EMPTY;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push_i) wr_ptr_d = ~wr_ptr_q;
            if (pop_i)  rd_ptr_d = ~rd_ptr_q;
            unique case (occ_q)
                EMPTY: if (push_i) occ_d = ONE;
                ONE: begin
                    if (push_i && !pop_i)      occ_d = TWO;
                    else if (!push_i && pop_i) occ_d = EMPTY;
                end
                // The issue logic never lets a push reach TWO without a pop.
                TWO:     if (pop_i && !push_i) occ_d = ONE;
                default: occ_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (sclr_i) begin
            occ_q    <= EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            occ_q    <= occ_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (sclr_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign occ_o   = occ_q;
    assign valid_o = (occ_q != EMPTY);
    assign dout_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/sync_fifo_reader.sv
// ----------------------------------------------------------------------------
// sync_fifo_reader
//   Read-side adapter for sync_fifo. Issues rd_en, absorbs the FIFO's
//   one-cycle read latency in a 2-entry skid buffer and presents the words as
//   a valid/ready stream at up to one beat per clock.
//
// Ports
//   clk        : clock, rising edge
//   sclr       : synchronous active-high reset (clear sync_fifo together)
//   flush      : synchronous discard of buffered and in-flight data
//   fifo_empty : empty from sync_fifo
//   fifo_dout  : dout from sync_fifo
//   fifo_rd_en : rd_en to sync_fifo
//   m_valid    : stream data valid
//   m_ready    : consumer accepts
//   m_data     : stream data (held stable while m_valid & !m_ready)
//   m_beats    : accepted-beat counter
//
// Build option
//   SYNC_FIFO_READER_STATS_EN : when defined, m_beats counts accepted beats
//   (16-bit, wrapping, cleared by sclr only). Otherwise m_beats is tied to 0.
// ----------------------------------------------------------------------------
module sync_fifo_reader
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  sclr,
    input  logic                  flush,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [BEATS_W-1:0]    m_beats
);

    occ_e       occ;
    logic [1:0] occ_bits;
    logic       pop;
    logic       inflight_q, inflight_d;
    logic [2:0] level_after;

    assign pop      = m_valid & m_ready;
    assign occ_bits = occ;

    // Entries that will be committed once everything already requested has
    // landed and this cycle's pop has left. Issuing only while this is below
    // two means a push can never meet a full buffer. The dependence on
    // m_ready keeps throughput at one beat per clock.
    assign level_after = {1'b0, occ_bits} + {2'b00, inflight_q} - {2'b00, pop};
    assign fifo_rd_en  = ~sclr & ~flush & ~fifo_empty & (level_after < 3'd2);

    // A read issued this cycle returns data after the edge; remember it so
    // that word is pushed at the following edge. Flush and reset force
    // fifo_rd_en low, which clears this flag at the same edge.
    assign inflight_d = fifo_rd_en;

    always_ff @(posedge clk) begin
        if (sclr) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    sync_fifo_reader_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk_i   (clk),
        .sclr_i  (sclr),
        .flush_i (flush),
        .push_i  (inflight_q),
        .pop_i   (pop),
        .din_i   (fifo_dout),
        .occ_o   (occ),
        .valid_o (m_valid),
        .dout_o  (m_data)
    );

`ifdef SYNC_FIFO_READER_STATS_EN
    logic [BEATS_W-1:0] beats_q, beats_d;

    // A pop during a flush cycle is still a completed transfer.
    assign beats_d = pop ? beats_q + BEATS_W'(1) : beats_q;

    always_ff @(posedge clk) begin
        if (sclr) begin
            beats_q <= '0;
        end else begin
            beats_q <= beats_d;
        end
    end

    assign m_beats = beats_q;
`else
    assign m_beats = '0;
`endif

endmodule

// File: tb/tb_sync_fifo_reader.sv
module tb_sync_fifo_reader;

    logic        clk = 1'b0;
    logic        sclr, flush, m_ready, wr_en;
    logic [7:0]  wr_data;
    logic        fifo_empty, fifo_rd_en, m_valid;
    logic [7:0]  fifo_dout, m_data;
    logic [15:0] m_beats;

    int n_checks = 0;
    int n_errors = 0;
    int underflow = 0;
    int usedw = 0;

    always #5 clk = ~clk;

    sync_fifo_reader #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .sclr       (sclr),
        .flush      (flush),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_beats    (m_beats)
    );

    // Behavioural sync_fifo: registered dout, one-cycle read latency.
    logic [7:0] fq[$];
    always @(posedge clk) begin
        if (sclr) begin
            fq.delete();
            fifo_dout <= 8'h00;
        end else begin
            if (fifo_rd_en === 1'b1) begin
                if (fq.size() > 0) fifo_dout <= fq.pop_front();
                else underflow <= underflow + 1;
            end
            if (wr_en) fq.push_back(wr_data);
        end
        usedw      <= fq.size();
        fifo_empty <= (fq.size() == 0);
    end

    function automatic logic [15:0] be(input int n);
`ifdef SYNC_FIFO_READER_STATS_EN
        return n[15:0];
`else
        return 16'h0000;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic f, input logic w,
                         input logic [7:0] d, input logic r);
        sclr = s; flush = f; wr_en = w; wr_data = d; m_ready = r;
        #1;
    endtask

    task automatic adv();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Hold ready high until the next beat appears and compare it.
    task automatic wait_beat(input logic [7:0] exp, input string nm);
        bit got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            drive(0, 0, 0, 8'h00, 1);
            if (m_valid === 1'b1) begin
                chk(nm, m_data, exp);
                got = 1;
            end
            adv();
        end
        chk({nm, "_timeout"}, {31'b0, got}, 1);
    endtask

    typedef struct packed {
        logic        sclr, flush, wr;
        logic [7:0]  wd;
        logic        rdy, en, e_rd, e_valid;
        logic [7:0]  e_data;
        logic        chk_data;
        logic [15:0] e_beats;
    } vec_t;

    function automatic vec_t mkv(logic s, logic f, logic w, logic [7:0] wd, logic r,
                                 logic en, logic erd, logic ev, logic [7:0] ed,
                                 logic cd, logic [15:0] eb);
        vec_t v;
        v = '{s, f, w, wd, r, en, erd, ev, ed, cd, eb};
        return v;
    endfunction

    initial begin
        vec_t vt[14];
        logic [7:0] exp_q[$];
        int idx;
        bit have_held;
        logic [7:0] held;
        int rd_cnt;
        int seen, wrote, bubbles, derr;
        bit started;

        // Reset, FIFO loaded under flush, reset held 2 cycles, then streaming.
        vt[0]  = mkv(1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0);
        vt[1]  = mkv(0, 1, 1, 8'hE1, 0, 1, 0, 0, 8'h00, 1, 0);
        vt[2]  = mkv(0, 1, 1, 8'hE2, 0, 1, 0, 0, 8'h00, 1, 0);
        vt[3]  = mkv(0, 1, 1, 8'hE3, 0, 1, 0, 0, 8'h00, 1, 0);
        vt[4]  = mkv(1, 0, 0, 8'h00, 1, 1, 0, 0, 8'h00, 1, 0);
        vt[5]  = mkv(1, 0, 0, 8'h00, 1, 1, 0, 0, 8'h00, 1, 0);
        vt[6]  = mkv(0, 0, 1, 8'h10, 1, 1, 0, 0, 8'h00, 0, 0);
        vt[7]  = mkv(0, 0, 1, 8'h11, 1, 1, 1, 0, 8'h00, 0, 0);
        vt[8]  = mkv(0, 0, 1, 8'h12, 1, 1, 1, 0, 8'h00, 0, 0);
        vt[9]  = mkv(0, 0, 1, 8'h13, 1, 1, 1, 1, 8'h10, 1, 0);
        vt[10] = mkv(0, 0, 0, 8'h00, 1, 1, 1, 1, 8'h11, 1, 1);
        vt[11] = mkv(0, 0, 0, 8'h00, 1, 1, 0, 1, 8'h12, 1, 2);
        vt[12] = mkv(0, 0, 0, 8'h00, 1, 1, 0, 1, 8'h13, 1, 3);
        vt[13] = mkv(0, 0, 0, 8'h00, 1, 1, 0, 0, 8'h00, 0, 4);

        for (int i = 0; i < 14; i++) begin
            drive(vt[i].sclr, vt[i].flush, vt[i].wr, vt[i].wd, vt[i].rdy);
            if (vt[i].en) begin
                chk($sformatf("vec%0d_rd_en", i), fifo_rd_en, vt[i].e_rd);
                chk($sformatf("vec%0d_valid", i), m_valid, vt[i].e_valid);
                if (vt[i].chk_data)
                    chk($sformatf("vec%0d_data", i), m_data, vt[i].e_data);
                chk($sformatf("vec%0d_beats", i), m_beats, be(int'(vt[i].e_beats)));
            end
            adv();
        end

        // Backpressure: 6 words written, consumer stalled for 10 cycles.
        rd_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            drive(0, 0, c < 6, 8'(8'hA0 + c), 0);
            if (fifo_rd_en === 1'b1) rd_cnt++;
            adv();
        end
        drive(0, 0, 0, 8'h00, 0);
        chk("bp_reads", rd_cnt, 2);
        chk("bp_usedw", usedw, 4);
        chk("bp_valid", m_valid, 1);
        chk("bp_data", m_data, 8'hA0);
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            drive(0, 0, 0, 8'h00, 1);
            if (m_valid === 1'b1) begin
                if (idx < 6) chk($sformatf("bp_beat%0d", idx), m_data, 8'(8'hA0 + idx));
                else chk("bp_extra_beat", m_valid, 0);
                idx++;
            end
            adv();
        end
        chk("bp_count", idx, 6);
        drive(0, 0, 0, 8'h00, 0);
        chk("bp_beats", m_beats, be(10));

        // Alternating ready over 8 words.
        idx = 0;
        have_held = 0;
        held = 8'h00;
        for (int c = 0; c < 40; c++) begin
            drive(0, 0, c < 8, 8'(c), c[0]);
            if (have_held) begin
                chk("alt_stall_valid", m_valid, 1);
                chk("alt_stall_hold", m_data, held);
            end
            if (m_valid === 1'b1 && m_ready) begin
                if (idx < 8) chk($sformatf("alt_beat%0d", idx), m_data, 8'(idx));
                else chk("alt_extra_beat", m_valid, 0);
                idx++;
            end
            have_held = (m_valid === 1'b1) && !m_ready;
            held = m_data;
            adv();
        end
        chk("alt_count", idx, 8);
        drive(0, 0, 0, 8'h00, 0);
        chk("alt_beats", m_beats, be(18));

        // Flush while full with the FIFO still holding 0x55; pop in flush cycle.
        drive(0, 0, 1, 8'h30, 0); adv();
        drive(0, 0, 1, 8'h31, 0); adv();
        drive(0, 0, 1, 8'h55, 0); adv();
        drive(0, 0, 0, 8'h00, 0); adv();
        drive(0, 0, 0, 8'h00, 0);
        chk("fl_full_valid", m_valid, 1);
        chk("fl_full_data", m_data, 8'h30);
        chk("fl_full_rd_en", fifo_rd_en, 0);
        chk("fl_usedw", usedw, 1);
        adv();
        drive(0, 1, 0, 8'h00, 1);
        chk("fl_cycle_rd_en", fifo_rd_en, 0);
        adv();
        drive(0, 0, 0, 8'h00, 0);
        chk("fl_after_valid", m_valid, 0);
        chk("fl_reissue_rd_en", fifo_rd_en, 1);
        adv();
        wait_beat(8'h55, "fl_next_beat");
        drive(0, 0, 0, 8'h00, 0);
        chk("fl_beats", m_beats, be(20));
        chk("fl_drained", m_valid, 0);

        // Flush with a read in flight: the returning word is dropped.
        drive(0, 0, 1, 8'h60, 0); adv();
        drive(0, 0, 0, 8'h00, 0);
        chk("fl2_rd_en", fifo_rd_en, 1);
        adv();
        drive(0, 1, 0, 8'h00, 0); adv();
        for (int c = 0; c < 4; c++) begin
            drive(0, 0, 0, 8'h00, 1);
            chk($sformatf("fl2_drop%0d", c), m_valid, 0);
            adv();
        end
        drive(0, 0, 1, 8'h62, 1); adv();
        wait_beat(8'h62, "fl2_next_beat");
        drive(0, 0, 0, 8'h00, 0);
        chk("fl2_beats", m_beats, be(21));

        // Reset with a read in flight.
        drive(0, 0, 1, 8'h70, 0); adv();
        drive(0, 0, 0, 8'h00, 0);
        chk("rst_mid_rd_en", fifo_rd_en, 1);
        adv();
        drive(1, 0, 0, 8'h00, 0);
        chk("rst_mid_rd_en_low", fifo_rd_en, 0);
        adv();
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 0, 8'h00, 1);
            chk($sformatf("rst_mid_valid%0d", c), m_valid, 0);
            adv();
        end
        drive(0, 0, 0, 8'h00, 0);
        chk("rst_mid_data", m_data, 8'h00);
        chk("rst_mid_beats", m_beats, 16'h0000);

        // 65536 back-to-back beats: throughput and counter wrap.
        seen = 0; wrote = 0; bubbles = 0; derr = 0; started = 0;
        for (int c = 0; c < 66000 && seen < 65536; c++) begin
            drive(0, 0, wrote < 65536, 8'(wrote), 1);
            if (m_valid === 1'b1) begin
                if (m_data !== 8'(seen)) derr++;
                if (seen == 65535) chk("wrap_beats_ffff", m_beats, be(65535));
                seen++;
                started = 1;
            end else if (started) begin
                bubbles++;
            end
            if (wrote < 65536) wrote++;
            adv();
        end
        drive(0, 0, 0, 8'h00, 0);
        chk("wrap_seen", seen, 65536);
        chk("wrap_data_errs", derr, 0);
        chk("wrap_bubbles", bubbles, 0);
        chk("wrap_beats_zero", m_beats, be(65536));
        chk("fifo_underflow", underflow, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
